// File: rtl/ram8_arbiter.sv
// Two-port arbiter in front of a single-ported 8x16 RAM. Each access takes one
// SERVE cycle followed by an IDLE/ack cycle in which the other port may be granted.
module ram8_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [2:0]  a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [2:0]  b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic [15:0] ram_in,
  output logic [2:0]  ram_address,
  output logic        ram_load,
  input  logic [15:0] ram_out
);
  localparam int NUM_PORTS = 2;
  localparam int AW        = 3;
  localparam int DW        = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

  cmd_t   [NUM_PORTS-1:0]         port_cmd;
  logic   [NUM_PORTS-1:0]         port_req;
  logic   [NUM_PORTS-1:0]         port_ack;
  logic   [NUM_PORTS-1:0]         port_done;
  logic   [NUM_PORTS-1:0]         elig;
  logic   [NUM_PORTS-1:0][DW-1:0] port_rdata;

  state_t state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  logic   last_grant_q, last_grant_d;  // 1 = B was granted last

  assign port_cmd[0] = {a_we, a_addr, a_wdata};
  assign port_cmd[1] = {b_we, b_addr, b_wdata};
  assign port_req    = {b_req, a_req};
  // A port in its ack cycle is ignored so its stale req cannot re-trigger.
  assign elig        = port_req & ~port_ack;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    last_grant_d = last_grant_q;
    port_done    = '0;
    ram_load     = 1'b0;
    ram_address  = '0;
    ram_in       = '0;
    case (state_q)
      IDLE: begin
        if (elig[0] && (!elig[1] || FIXED_PRIORITY || last_grant_q)) begin
          state_d = SERVE_A;
          cmd_d   = port_cmd[0];
        end else if (elig[1]) begin
          state_d = SERVE_B;
          cmd_d   = port_cmd[1];
        end
      end
      SERVE_A, SERVE_B: begin
        ram_load     = cmd_q.we;
        ram_address  = cmd_q.addr;
        ram_in       = cmd_q.wdata;
        port_done[0] = (state_q == SERVE_A);
        port_done[1] = (state_q == SERVE_B);
        last_grant_d = (state_q == SERVE_B);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Per-port completion: read data is captured before the write edge lands,
  // so a write returns the word's previous contents.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic          ack_d, ack_q;
    logic [DW-1:0] rdata_d, rdata_q;

    always_comb begin
      ack_d   = port_done[p];
      rdata_d = port_done[p] ? ram_out : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ack_q   <= 1'b0;
        rdata_q <= '0;
      end else begin
        ack_q   <= ack_d;
        rdata_q <= rdata_d;
      end
    end

    assign port_ack[p]   = ack_q;
    assign port_rdata[p] = rdata_q;
  end

  assign a_ack   = port_ack[0];
  assign b_ack   = port_ack[1];
  assign a_rdata = port_rdata[0];
  assign b_rdata = port_rdata[1];

endmodule
